// File: rtl/issue_queue_pkg.sv
// Shared types for the decode -> issue instruction queue.
package issue_queue_pkg;

    localparam int ISSUE_QUEUE_DEPTH = 8;

    typedef logic [$clog2(ISSUE_QUEUE_DEPTH)-1:0] IQ_PTR;

    // One decoded instruction as handed from decode to issue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/issue_queue_if.sv
// Decode/issue handshake bundle for the issue queue.
// The master modport is the pipeline side and the slave modport is the queue.
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_QUEUE_DEPTH
) ();

    logic                          flash;
    logic                          stall;
    logic [1:0]                    push_number;
    ISSUE_QUEUE_ELEMENT [1:0]      push_data;
    logic                          push_ready;
    ISSUE_QUEUE_ELEMENT [1:0]      issue_require;
    logic [1:0]                    iq_size;
    logic [1:0]                    iq_pop_number;
    logic [$clog2(DEPTH):0]        iq_count;

    modport master (
        output flash, stall, push_number, push_data, iq_pop_number,
        input  push_ready, issue_require, iq_size, iq_count
    );

    modport slave (
        input  flash, stall, push_number, push_data, iq_pop_number,
        output push_ready, issue_require, iq_size, iq_count
    );

endinterface

// File: rtl/issue_queue_iq_ram.sv
// Issue queue storage: DEPTH entries, two write ports, two asynchronous read ports.
// The two write addresses are always distinct in use (tail and tail+1).
module iq_ram
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we0,
    input  logic [AW-1:0]      waddr0,
    input  ISSUE_QUEUE_ELEMENT wdata0,
    input  logic               we1,
    input  logic [AW-1:0]      waddr1,
    input  ISSUE_QUEUE_ELEMENT wdata1,
    input  logic [AW-1:0]      raddr0,
    output ISSUE_QUEUE_ELEMENT rdata0,
    input  logic [AW-1:0]      raddr1,
    output ISSUE_QUEUE_ELEMENT rdata1
);

    ISSUE_QUEUE_ELEMENT mem [DEPTH];

    // Data array is not reset; validity is tracked by the queue count.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/issue_queue.sv
// In-order dual-push / dual-pop instruction queue between decode and issue.
// Circular buffer with registered head, tail and count; flash empties it.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_QUEUE_DEPTH
) (
    input logic          clk,
    input logic          rst_n,
    issue_queue_if.slave iq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [PTR_W-1:0]   head_next_slot;
    logic [PTR_W-1:0]   tail_next_slot;
    logic [1:0]         size;
    logic               ready;
    logic [1:0]         push_req;
    logic [1:0]         push_eff;
    logic [1:0]         pop_eff;
    logic [CNT_W-1:0]   count_next;
    ISSUE_QUEUE_ELEMENT rd0;
    ISSUE_QUEUE_ELEMENT rd1;

    assign head_next_slot = head + PTR_W'(1);
    assign tail_next_slot = tail + PTR_W'(1);

    // Status outputs come from registered count only, so no input reaches them.
    assign size  = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
    assign ready = (count <= CNT_W'(DEPTH - 2));

    // Effective push/pop: saturate requests, clamp pops to what is present.
    always_comb begin
        push_req = (iq.push_number == 2'd3) ? 2'd2 : iq.push_number;
        push_eff = 2'd0;
        pop_eff  = 2'd0;
        if (!iq.flash) begin
            if (ready) begin
                push_eff = push_req;
            end
            if (!iq.stall) begin
                pop_eff = (iq.iq_pop_number > size) ? size : iq.iq_pop_number;
            end
        end
        count_next = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end

    // Pointer and occupancy state; flash overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (iq.flash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_eff);
            tail  <= tail + PTR_W'(push_eff);
            count <= count_next;
        end
    end

    // Decode must never push while the queue cannot take two entries.
    always_ff @(posedge clk) begin
        if (rst_n && !iq.flash) begin
            assert (ready || iq.push_number == 2'd0);
        end
    end

    iq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we0    (push_eff != 2'd0),
        .waddr0 (tail),
        .wdata0 (iq.push_data[0]),
        .we1    (push_eff == 2'd2),
        .waddr1 (tail_next_slot),
        .wdata1 (iq.push_data[1]),
        .raddr0 (head),
        .rdata0 (rd0),
        .raddr1 (head_next_slot),
        .rdata1 (rd1)
    );

    // Read side is purely from stored entries: a same-cycle push never falls through.
    assign iq.issue_require[0] = (count >= CNT_W'(1)) ? rd0 : '0;
    assign iq.issue_require[1] = (count >= CNT_W'(2)) ? rd1 : '0;
    assign iq.iq_size          = size;
    assign iq.iq_count         = count;
    assign iq.push_ready       = ready;

endmodule
